// File: rtl/ascon_pack.sv
// ascon_pack: shared state type, round constants and FSM encoding for the ASCON permutation
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
  typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm;
  localparam logic [3:0] PA_FIRST = 4'd0;
  localparam logic [3:0] PB_FIRST = 4'd6;
  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [0:11][7:0] RC = {
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };
  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction
endpackage

// File: rtl/permutation_iter_round.sv
// round_function: one combinational ASCON round (pc, ps, pl) built from its three layers
module constant_addition
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);
  // fold the round constant into the low byte of x2
  always_comb begin
    state_o = state_i;
    state_o[2][7:0] = state_i[2][7:0] ^ RC[round_i];
  end
endmodule

module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  logic [63:0] b0, b1, b2, b3, b4, c0, c1, c2, c3, c4;
  // bitsliced 5-bit s-box applied to all 64 columns at once
  always_comb begin
    b0 = state_i[0] ^ state_i[4];
    b1 = state_i[1];
    b2 = state_i[2] ^ state_i[1];
    b3 = state_i[3];
    b4 = state_i[4] ^ state_i[3];
    c0 = b0 ^ (~b1 & b2);
    c1 = b1 ^ (~b2 & b3);
    c2 = b2 ^ (~b3 & b4);
    c3 = b3 ^ (~b4 & b0);
    c4 = b4 ^ (~b0 & b1);
    state_o[0] = c0 ^ c4;
    state_o[1] = c1 ^ c0;
    state_o[2] = ~c2;
    state_o[3] = c3 ^ c2;
    state_o[4] = c4;
  end
endmodule

module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  // per-word linear mixing with the fixed rotation pairs
  always_comb begin
    state_o[0] = state_i[0] ^ ror(state_i[0], 19) ^ ror(state_i[0], 28);
    state_o[1] = state_i[1] ^ ror(state_i[1], 61) ^ ror(state_i[1], 39);
    state_o[2] = state_i[2] ^ ror(state_i[2], 1) ^ ror(state_i[2], 6);
    state_o[3] = state_i[3] ^ ror(state_i[3], 10) ^ ror(state_i[3], 17);
    state_o[4] = state_i[4] ^ ror(state_i[4], 7) ^ ror(state_i[4], 41);
  end
endmodule

module round_function
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);
  type_state pc_out, ps_out;
  constant_addition u_pc (.state_i(state_i), .round_i(round_i), .state_o(pc_out));
  substitution_layer u_ps (.state_i(pc_out), .state_o(ps_out));
  diffusion_layer u_pl (.state_i(ps_out), .state_o(state_o));
endmodule

// File: rtl/permutation_iter.sv
// permutation_iter: iterative ASCON pa/pb permutation, one round per clock
module permutation_iter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);
  type_fsm fsm, fsm_next;
  type_state state_q, round_out;
  logic [3:0] round_q;
  logic accept;
  assign accept = fsm == IDLE && start_i;
  round_function u_round (.state_i(state_q), .round_i(round_q), .state_o(round_out));
  // FSM state register
  always_ff @(posedge clock_i) begin
    if (reset_i) fsm <= IDLE;
    else fsm <= fsm_next;
  end
  // next state: run until the round-11 update, then a single DONE cycle
  always_comb begin
    fsm_next = IDLE;
    fsm_next = fsm == IDLE ? (start_i ? RUN : IDLE) :
               fsm == RUN  ? (round_q == LAST_ROUND ? DONE : RUN) : IDLE;
  end
  // state register and round counter; the counter parks at the last round
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= '0;
      round_q <= '0;
    end else if (accept) begin
      state_q <= state_i;
      round_q <= mode_i ? PB_FIRST : PA_FIRST;
    end else if (fsm == RUN) begin
      state_q <= round_out;
      round_q <= round_q == LAST_ROUND ? round_q : round_q + 4'd1;
    end
  end
  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o = fsm == RUN;
  assign done_o = fsm == DONE;
endmodule

// File: doc/permutation_iter.md
PERMUTATION_ITER -- requirements
Module: permutation_iter

Interface
REQ-001 Parameters: none; round counts are fixed by the ASCON pa and pb permutations.
REQ-002 clock_i  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 start_i  input  1  request to permute state_i; sampled only in IDLE.
REQ-005 mode_i  input  1  0 = pa (12 rounds, constants index 0..11); 1 = pb (6 rounds, index 6..11); sampled with start_i.
REQ-006 state_i  input  type_state (5x64)  permutation input, sampled with start_i.
REQ-007 state_o  output  type_state (5x64)  state register contents.
REQ-008 round_o  output  4  current round index, 0..11.
REQ-009 busy_o  output  1  high in RUN.
REQ-010 done_o  output  1  one-cycle pulse; state_o is the final permutation result while it is high.

Function
REQ-011 FSM states: IDLE, RUN, DONE.
REQ-012 IDLE with start_i=1: state register <= state_i; round <= 0 (mode_i=0) or 6 (mode_i=1); go to RUN.
REQ-013 IDLE with start_i=0: hold all registers; done_o=0, busy_o=0.
REQ-014 RUN, every cycle: state register <= pl(ps(pc(state register, round))).
REQ-015 pc XORs round constant RC[round] into bits [7:0] of word x2.
REQ-016 RC[0..11] = f0,e1,d2,c3,b4,a5,96,87,78,69,5a,4b (hex).
REQ-017 RUN: round increments by 1 per cycle. The update at round 11 moves the FSM to DONE and leaves round at 11, with no wrap.
REQ-018 DONE lasts exactly one cycle: done_o=1, state register held, then return to IDLE.
REQ-019 Latency, with start accepted at edge k: done_o is high during cycle k+13 (pa) or k+7 (pb).
REQ-020 start_i in RUN or DONE is ignored; no queuing, and the operation in flight completes unchanged.
REQ-021 start_i in the IDLE cycle that immediately follows DONE is accepted normally, giving back-to-back operation with one IDLE cycle.
REQ-022 state_o holds the last result until the next accepted start; it is not cleared on return to IDLE.
REQ-023 state_i and mode_i changes after acceptance have no effect on the operation in flight.
REQ-024 busy_o and done_o are never high in the same cycle.

Reset
REQ-025 reset_i=1 at any clock edge forces: FSM IDLE, state register all-zero, round 0, busy_o=0, done_o=0.
REQ-026 Reset has priority over start_i and over a running permutation; a reset mid-RUN aborts with no done_o pulse.
REQ-027 The first start_i is accepted at the first edge where reset_i=0.

Structure
REQ-028 type_state, the round-constant table RC, and the FSM state enum shall live in ascon_pack.
REQ-029 The combinational round datapath (pc, ps, pl) shall be one sub-module, round_function, that chains the existing constant_addition, substitution_layer and diffusion_layer blocks.
REQ-030 permutation_iter shall contain only the FSM, the round counter and the 320-bit state register.

Verification
REQ-031 Reset then idle: state_o=0, round_o=0, busy_o=0, done_o=0 for 5 cycles with start_i=0.
REQ-032 pa on all-zero state: start at edge k -> busy_o high k+1..k+12; round_o steps 0,1,...,11; done_o high only at k+13; state_o equals the bench model's 12-round result.
REQ-033 pb on state x0..x4 = 8859263f4c5d6e8f, 00c18e8584858607, 7f7f7f7f7f7f7f8f, 80c0848680808070, 8888888a88888888 -> round_o steps 6..11; done_o at k+7; state_o matches the 6-round model.
REQ-034 start_i held high continuously in pb mode -> operations complete every 8 cycles, with done_o pulses 8 cycles apart and one IDLE cycle between operations.
REQ-035 Change state_i and mode_i, and pulse start_i, during RUN -> result and latency are identical to an undisturbed run.
REQ-036 Assert reset_i at round 5 of a pa run -> next cycle state_o=0, round_o=0, busy_o=0, and no done_o pulse.
